// File: rtl/boreal_pkg.sv
// boreal_pkg: shared verdict codes, request word indices, policy defaults and FSM states
package boreal_pkg;
   localparam logic [31:0] DEF_EXP_POLICY = 32'hA5A5_0001;
   localparam logic [31:0] DEF_MAX_MAG    = 32'd100;
   localparam logic [31:0] V_ALLOW       = 32'd1;
   localparam logic [31:0] V_DENY_VER    = 32'd2;
   localparam logic [31:0] V_DENY_POL    = 32'd3;
   localparam logic [31:0] V_DENY_MAG    = 32'd4;
   localparam logic [31:0] V_DENY_REPLAY = 32'd5;
   localparam int W_VER    = 0;
   localparam int W_CLASS  = 1;
   localparam int W_MAG    = 2;
   localparam int W_POLICY = 5;
   localparam int W_NONCE  = 7;
   typedef enum logic [1:0] {IDLE, CHECK, RESP} state_t;
endpackage

// File: rtl/boreal_resp_verdict.sv
// boreal_resp_verdict: combinational request verdict with fixed check priority
module boreal_resp_verdict
   import boreal_pkg::*;
#(
   parameter logic [31:0] EXP_POLICY = DEF_EXP_POLICY,
   parameter logic [31:0] MAX_MAG    = DEF_MAX_MAG
) (
   input  logic [31:0] ver,
   input  logic [31:0] mag,
   input  logic [31:0] policy,
   input  logic [31:0] nonce,
   input  logic [31:0] exp_nonce,
   output logic [31:0] verdict
);
   // first failing check wins; replay is checked before magnitude
   always_comb
      verdict = (ver != 32'd1)         ? V_DENY_VER    :
                (policy != EXP_POLICY) ? V_DENY_POL    :
                (nonce < exp_nonce)    ? V_DENY_REPLAY :
                (mag > MAX_MAG)        ? V_DENY_MAG    : V_ALLOW;
endmodule

// File: rtl/boreal_mailbox_responder.sv
// boreal_mailbox_responder: request word mailbox with one-cycle policy check and held response
module boreal_mailbox_responder
   import boreal_pkg::*;
#(
   parameter logic [31:0] EXP_POLICY = DEF_EXP_POLICY,
   parameter logic [31:0] MAX_MAG    = DEF_MAX_MAG
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_we,
   input  logic [3:0]  req_widx,
   input  logic [31:0] req_wdata,
   input  logic        req_valid_set,
   output logic        resp_valid,
   output logic [31:0] resp_w0,
   output logic [31:0] resp_w1,
   output logic [31:0] resp_w2,
   output logic [31:0] resp_w3,
   output logic [31:0] resp_w4,
   input  logic        resp_ack,
   output logic        busy,
   output logic        err_wr_busy
);
   state_t      state, state_nxt;
   logic [31:0] words [8];
   logic [31:0] exp_nonce, seq, verdict, req_xor;

   boreal_resp_verdict #(.EXP_POLICY(EXP_POLICY), .MAX_MAG(MAX_MAG)) u_verdict (
      .ver       (words[W_VER]),
      .mag       (words[W_MAG]),
      .policy    (words[W_POLICY]),
      .nonce     (words[W_NONCE]),
      .exp_nonce (exp_nonce),
      .verdict   (verdict)
   );

   assign busy = state != IDLE;

   // folded checksum of the whole request
   always_comb begin
      req_xor = '0;
      for (int i = 0; i < 8; i++) req_xor ^= words[i];
   end

   // acks only count once the response is actually presented
   always_comb
      state_nxt = (state == IDLE && req_valid_set)         ? CHECK :
                  (state == CHECK)                         ? RESP  :
                  (state == RESP && resp_valid && resp_ack) ? IDLE  : state;

   // state register, busy-drop flag and response handshake
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         resp_valid  <= 1'b0;
         err_wr_busy <= 1'b0;
      end else begin
         state       <= state_nxt;
         resp_valid  <= state == RESP && !(resp_valid && resp_ack);
         if (busy && (req_we || req_valid_set)) err_wr_busy <= 1'b1;
      end
   end

   // request word file, writable only while idle; indices 8..15 are dropped
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 8; i++) words[i] <= '0;
      end else if (state == IDLE && req_we && !req_widx[3]) begin
         words[req_widx[2:0]] <= req_wdata;
      end
   end

   // response words, replay window and sequence counter update during CHECK
   always_ff @(posedge clk) begin
      if (rst) begin
         resp_w0   <= '0;
         resp_w1   <= '0;
         resp_w2   <= '0;
         resp_w3   <= '0;
         resp_w4   <= '0;
         exp_nonce <= '0;
         seq       <= '0;
      end else if (state == CHECK) begin
         resp_w0 <= verdict;
         resp_w1 <= words[W_NONCE];
         resp_w2 <= (verdict == V_ALLOW) ? words[W_MAG] : '0;
         resp_w3 <= seq;
         resp_w4 <= req_xor;
         seq     <= seq + 32'd1;
         if (verdict != V_DENY_REPLAY) exp_nonce <= words[W_NONCE] + 32'd1;
      end
   end
endmodule
